// File: rtl/uart_tx_if.sv
// Parallel-side handshake and frame configuration for the UART transmitter.
// The master (host) drives the request and config. The slave (uart_tx) returns the line and status.
interface uart_tx_if;
    logic [1:0] i_num_bit_data;
    logic       i_parity_en;
    logic       i_parity_type;
    logic       i_stop_bits;
    logic [7:0] i_data;
    logic       i_tx_start;
    logic       o_tx_serial;
    logic       o_tx_busy;
    logic       o_tx_done;

    modport master (
        output i_num_bit_data, i_parity_en, i_parity_type, i_stop_bits, i_data, i_tx_start,
        input  o_tx_serial, o_tx_busy, o_tx_done
    );

    modport slave (
        input  i_num_bit_data, i_parity_en, i_parity_type, i_stop_bits, i_data, i_tx_start,
        output o_tx_serial, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Bit timing comes from an external oversampling tick shared with uart_rx.
module uart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tx_tick,
    uart_tx_if.slave tx
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    last_bit_q, last_bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          stop2_q, stop2_d;
    logic          serial_q, serial_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    data_mask;
    logic          bit_end;

    // Parity is resolved at accept time, so later input changes cannot affect it.
    assign data_mask = 8'hFF >> (2'd3 - tx.i_num_bit_data);
    assign bit_end   = tx_tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        done_d     = 1'b0;

        if (state_q != IDLE && tx_tick)
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (tx.i_tx_start) begin
                    shift_d    = tx.i_data & data_mask;
                    last_bit_d = 3'd4 + {1'b0, tx.i_num_bit_data};
                    par_en_d   = tx.i_parity_en;
                    par_bit_d  = (^(tx.i_data & data_mask)) ^ tx.i_parity_type;
                    stop2_d    = tx.i_stop_bits;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == last_bit_q) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == {2'b00, stop2_q}) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is decoded from the next state, so the registered output never glitches.
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_bit_q;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx.o_tx_serial = serial_q;
    assign tx.o_tx_busy   = busy_q;
    assign tx.o_tx_done   = done_q;
endmodule
